// File: rtl/skid_buffer.sv
// skid_buffer: two-entry registered valid/ready slice (output reg + skid reg).
// Every output is a flop, so no combinational path crosses the slice in either direction.
module skid_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_e;
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] oreg_q, oreg_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic                  valid_q, valid_d;
    logic                  ready_q, ready_d;
    logic                  in_fire, out_fire;
    assign in_fire        = data_in_valid & ready_q;
    assign out_fire       = valid_q & data_out_ready;
    assign data_in_ready  = ready_q;
    assign data_out_valid = valid_q;
    assign data_out       = oreg_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            oreg_q  <= '0;
            sreg_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            oreg_q  <= oreg_d;
            sreg_q  <= sreg_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end
    always_comb begin
        case (state_q)
            EMPTY:   state_d = in_fire ? BUSY : EMPTY;
            BUSY:    state_d = (in_fire && !out_fire) ? FULL :
                               (!in_fire && out_fire) ? EMPTY : BUSY;
            FULL:    state_d = out_fire ? BUSY : FULL;
            default: state_d = EMPTY;
        endcase
    end
    // Flags are decoded from the next state so they land in flops alongside it.
    always_comb begin
        valid_d = state_d != EMPTY;
        ready_d = state_d != FULL;
        oreg_d  = (in_fire && (state_q == EMPTY || (state_q == BUSY && out_fire))) ? data_in :
                  (state_q == FULL && out_fire) ? sreg_q : oreg_q;
        sreg_d  = (state_q == BUSY && in_fire && !out_fire) ? data_in : sreg_q;
    end
endmodule
